// File: rtl/i2df96_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : i2df96_conv                                                  |
// | Description : 96-bit signed/unsigned integer to 96-bit decimal float        |
// |               (sign, 11-bit exponent bias 1023, 21 BCD digits).            |
// |               Option macro I2DF96_INEXACT_EN adds the inexact flag output. |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module i2df96_conv (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        op,
  input  logic [2:0]  rm,
  input  logic        ld,
  input  logic [95:0] i,
  output logic [95:0] o,
  output logic        done
`ifdef I2DF96_INEXACT_EN
  ,
  output logic        inexact
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_NORM = 3'd2,
    S_RND  = 3'd3,
    S_PACK = 3'd4
  } state_t;

  state_t        state_q;
  logic [6:0]    cnt_q;
  logic [95:0]   bin_q;
  logic [115:0]  bcd_q;
  logic          sign_q;
  logic [2:0]    rm_q;
  logic [5:0]    n_q;
  logic          zero_q;
  logic [83:0]   sig_q;
  logic [95:0]   o_q;
  logic          done_q;
`ifdef I2DF96_INEXACT_EN
  logic          inex_q;
  logic          inexact_q;
`endif

  logic [115:0]  w_adj;
  logic [115:0]  w_bcd_shift;
  logic [4:0]    w_lz;
  logic [115:0]  w_norm;
  logic [5:0]    w_n;
  logic [83:0]   w_kept;
  logic [3:0]    w_guard;
  logic          w_sticky;
  logic          w_rest_nz;
  logic          w_up;
  logic [83:0]   w_inc;
  logic [21:0]   w_carry;
  logic [83:0]   sig_d;
  logic [5:0]    n_rnd_d;
  logic [10:0]   w_exp;
  logic [95:0]   mag_d;
  logic          sign_d;

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  genvar gd;
  generate
    for (gd = 0; gd < 29; gd++) begin : g_dabble
      logic [3:0] w_dig;
      assign w_dig = bcd_q[4*gd +: 4];
      assign w_adj[4*gd +: 4] = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
    end
  endgenerate

  assign w_bcd_shift = 116'({w_adj, bin_q[95]});

  always_comb begin
    w_lz = 5'd29;
    for (int k = 0; k < 29; k++) begin
      if (bcd_q[4*k +: 4] != 4'd0) w_lz = 5'(28 - k);
    end
  end

  assign w_norm = bcd_q << {w_lz, 2'b00};
  assign w_n    = 6'd29 - {1'b0, w_lz};

  assign w_kept    = bcd_q[115:32];
  assign w_guard   = bcd_q[31:28];
  assign w_sticky  = |bcd_q[27:0];
  assign w_rest_nz = (w_guard != 4'd0) | w_sticky;

  always_comb begin
    case (rm_q)
      3'd1:    w_up = 1'b0;
      3'd2:    w_up = w_rest_nz & ~sign_q;
      3'd3:    w_up = w_rest_nz & sign_q;
      3'd4:    w_up = (w_guard >= 4'd5);
      default: w_up = (w_guard > 4'd5) |
                      ((w_guard == 4'd5) & (w_sticky | bcd_q[32]));
    endcase
  end

  // Decimal +1 on the kept significand, rippling through trailing 9s.
  assign w_carry[0] = 1'b1;
  genvar gi;
  generate
    for (gi = 0; gi < 21; gi++) begin : g_inc
      logic [3:0] w_dig;
      assign w_dig = w_kept[4*gi +: 4];
      assign w_inc[4*gi +: 4] = !w_carry[gi] ? w_dig :
                                (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;
      assign w_carry[gi+1] = w_carry[gi] & (w_dig == 4'd9);
    end
  endgenerate

  always_comb begin
    sig_d   = w_kept;
    n_rnd_d = n_q;
    if (w_up) begin
      if (w_carry[21]) begin
        sig_d   = {4'h1, 80'h0};
        n_rnd_d = n_q + 6'd1;
      end else begin
        sig_d = w_inc;
      end
    end
  end

  assign w_exp  = 11'd1022 + {5'd0, n_q};
  assign sign_d = op & i[95];
  assign mag_d  = sign_d ? (96'd0 - i) : i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      rm_q    <= '0;
      n_q     <= '0;
      zero_q  <= 1'b0;
      sig_q   <= '0;
      o_q     <= '0;
      done_q  <= 1'b0;
`ifdef I2DF96_INEXACT_EN
      inex_q    <= 1'b0;
      inexact_q <= 1'b0;
`endif
    end else if (ce) begin
      if (ld) begin
        sign_q  <= sign_d;
        bin_q   <= mag_d;
        rm_q    <= rm;
        bcd_q   <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
`ifdef I2DF96_INEXACT_EN
        inexact_q <= 1'b0;
`endif
        state_q <= S_CONV;
      end else begin
        case (state_q)
          S_IDLE: state_q <= S_IDLE;
          S_CONV: begin
            bcd_q <= w_bcd_shift;
            bin_q <= {bin_q[94:0], 1'b0};
            cnt_q <= cnt_q + 7'd1;
            if (cnt_q == 7'd95) state_q <= S_NORM;
          end
          S_NORM: begin
            bcd_q   <= w_norm;
            n_q     <= w_n;
            zero_q  <= (w_lz == 5'd29);
            state_q <= S_RND;
          end
          S_RND: begin
            sig_q   <= sig_d;
            n_q     <= n_rnd_d;
`ifdef I2DF96_INEXACT_EN
            inex_q  <= w_rest_nz;
`endif
            state_q <= S_PACK;
          end
          S_PACK: begin
            o_q     <= zero_q ? 96'h0 : {sign_q, w_exp, sig_q};
            done_q  <= 1'b1;
`ifdef I2DF96_INEXACT_EN
            inexact_q <= inex_q;
`endif
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign o    = o_q;
  assign done = done_q;
`ifdef I2DF96_INEXACT_EN
  assign inexact = inexact_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2df96_conv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_i2df96_conv                                               |
// | Description : directed self-checking bench for i2df96_conv                 |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_i2df96_conv;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        op;
  logic [2:0]  rm;
  logic        ld;
  logic [95:0] i;
  logic [95:0] o;
  logic        done;
`ifdef I2DF96_INEXACT_EN
  logic        inexact;
`endif

  int vectors;
  int miscompares;
  int lat;

  localparam logic [95:0] P21   = 96'h0000_0036_35C9_ADC5_DEA0_0000; // 10^21
  localparam logic [95:0] P22M1 = 96'h0000_021E_19E0_C9BA_B23F_FFFF; // 10^22-1

  i2df96_conv dut (
    .clk  (clk),
    .rst  (rst),
    .ce   (ce),
    .op   (op),
    .rm   (rm),
    .ld   (ld),
    .i    (i),
    .o    (o),
    .done (done)
`ifdef I2DF96_INEXACT_EN
    ,
    .inexact (inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic start(input logic op_v, input logic [2:0] rm_v, input logic [95:0] i_v);
    op = op_v;
    rm = rm_v;
    i  = i_v;
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic conv(input string tag, input logic op_v, input logic [2:0] rm_v,
                      input logic [95:0] i_v, input logic [95:0] expv);
    start(op_v, rm_v, i_v);
    wait_done(lat);
    chk({tag, "_lat"}, 96'(lat), 96'd99);
    chk(tag, o, expv);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1; ce = 1'b1; ld = 1'b0; op = 1'b0; rm = 3'd0; i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_o", o, 96'h0);
    chk("reset_done", 96'(done), 96'd0);
    rst = 1'b0;

    conv("one",   1'b0, 3'd0, 96'd1,        96'h3FF1_0000_0000_0000_0000_0000);
    conv("ten",   1'b0, 3'd0, 96'd10,       96'h4001_0000_0000_0000_0000_0000);
    conv("12345678", 1'b0, 3'd0, 96'd12345678, 96'h4061_2345_6780_0000_0000_0000);
    repeat (10) @(posedge clk);
    #1;
    chk("done_hold", 96'(done), 96'd1);
    chk("o_hold", o, 96'h4061_2345_6780_0000_0000_0000);

    conv("neg1",  1'b1, 3'd0, {96{1'b1}},   96'hBFF1_0000_0000_0000_0000_0000);
    conv("zero",  1'b0, 3'd2, 96'd0,        96'h0);
    conv("tie_even_rm0", 1'b0, 3'd0, P21 + 96'd5, 96'h4141_0000_0000_0000_0000_0000);
`ifdef I2DF96_INEXACT_EN
    chk("inexact_tie", 96'(inexact), 96'd1);
`endif
    conv("tie_rm2", 1'b0, 3'd2, P21 + 96'd5, 96'h4141_0000_0000_0000_0000_0001);
    conv("tie_rm4", 1'b0, 3'd4, P21 + 96'd5, 96'h4141_0000_0000_0000_0000_0001);
    conv("tie_rm6", 1'b0, 3'd6, P21 + 96'd5, 96'h4141_0000_0000_0000_0000_0000);
    conv("tie_odd_rm0", 1'b0, 3'd0, P21 + 96'd15, 96'h4141_0000_0000_0000_0000_0002);
    conv("neg_rm3", 1'b1, 3'd3, 96'd0 - (P21 + 96'd5), 96'hC141_0000_0000_0000_0000_0001);
    conv("neg_rm2", 1'b1, 3'd2, 96'd0 - (P21 + 96'd5), 96'hC141_0000_0000_0000_0000_0000);
    conv("max_rm1", 1'b0, 3'd1, {96{1'b1}}, 96'h41B7_9228_1625_1426_4337_5935);
    conv("minint_op1", 1'b1, 3'd0, {1'b1, 95'd0}, 96'hC1B3_9614_0812_5713_2168_7968);
    conv("2p95_op0", 1'b0, 3'd1, {1'b1, 95'd0}, 96'h41B3_9614_0812_5713_2168_7967);
    conv("carry_out", 1'b0, 3'd0, P22M1, 96'h4151_0000_0000_0000_0000_0000);
    conv("exact_small", 1'b0, 3'd2, 96'd7, 96'h3FF7_0000_0000_0000_0000_0000);
`ifdef I2DF96_INEXACT_EN
    chk("inexact_exact", 96'(inexact), 96'd0);
`endif

    // Restart: a second ld mid-conversion replaces the first operand.
    start(1'b0, 3'd0, 96'd1);
    repeat (50) @(posedge clk);
    #1;
    chk("restart_busy_done", 96'(done), 96'd0);
    conv("restart", 1'b0, 3'd0, 96'd10, 96'h4001_0000_0000_0000_0000_0000);

    // Stall: 30 edges with ce low part-way through the conversion.
    start(1'b0, 3'd0, 96'd12345678);
    repeat (20) @(posedge clk);
    #1;
    ce = 1'b0;
    ld = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    ld = 1'b0;
    chk("stall_done", 96'(done), 96'd0);
    ce = 1'b1;
    wait_done(lat);
    chk("stall_lat", 96'(lat), 96'd79);
    chk("stall_o", o, 96'h4061_2345_6780_0000_0000_0000);

    // Reset mid-operation clears the result and leaves the unit idle.
    start(1'b0, 3'd0, 96'd1);
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid_done", 96'(done), 96'd0);
    chk("rst_mid_o", o, 96'h0);
    repeat (120) @(posedge clk);
    #1;
    chk("rst_idle_done", 96'(done), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
